sbus_resp: RTL and testbench

- Synthesizable simple-bus responder (slave) with internal word memory. It is the DUT-side counterpart of the testbench bus driver.
- It accepts one request through a valid/ready request channel and returns one response through a valid/ready response channel after a programmable number of wait states.
- It reports errors for misaligned or out-of-range addresses.
- It is used as the target memory in driver/monitor/agent-based benches and as a generic register/memory slave in SoC fabrics.

---
 rtl/sbus_resp.sv | 219 +++++++++++++++++++++
 tb/tb_sbus_resp.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbus_resp.sv
// sbus_resp: simple-bus responder with an internal word memory.
//
// One request is accepted on the req_* valid/ready channel. After wait_cnt wait states
// the access is performed and one response is returned on the rsp_* valid/ready channel.
// A misaligned address, or a word index at or beyond DEPTH, gives rsp_err=1 with no
// memory write and rsp_rdata=0.
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   wait_cnt              wait states for the next transaction, sampled at accept
//   req_valid/req_ready   request handshake
//   req_we/req_addr/req_wdata/req_be   request payload (byte address, byte lanes)
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata/rsp_err     response payload
//
// Optional feature (macro SBUS_RESP_STAT_EN): adds the saturating 16-bit handshake
// counters stat_rd_cnt, stat_wr_cnt and stat_err_cnt.

module sbus_resp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned WAIT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WAIT_W-1:0]     wait_cnt,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err
`ifdef SBUS_RESP_STAT_EN
  ,
  output logic [15:0]           stat_rd_cnt,
  output logic [15:0]           stat_wr_cnt,
  output logic [15:0]           stat_err_cnt
`endif
);

  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned OFF_W  = $clog2(BE_W);
  localparam int unsigned IDX_W  = ADDR_W - OFF_W;
  localparam int unsigned MEM_AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q, rsp_err_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept;
  logic                enter_resp;
  logic                mem_we;
  logic                acc_we;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;
  logic [BE_W-1:0]     acc_be;
  logic [IDX_W-1:0]    acc_idx;
  logic [MEM_AW-1:0]   acc_widx;
  logic                acc_err;

  assign req_ready = (state_q == StIdle) && !rst;
  assign accept    = req_valid && req_ready;

  // A zero-wait accept performs the access on the accept edge itself, so it must use the
  // live request; every other access uses the latched copy.
  assign acc_we    = (state_q == StIdle) ? req_we    : we_q;
  assign acc_addr  = (state_q == StIdle) ? req_addr  : addr_q;
  assign acc_wdata = (state_q == StIdle) ? req_wdata : wdata_q;
  assign acc_be    = (state_q == StIdle) ? req_be    : be_q;
  assign acc_idx   = acc_addr[ADDR_W-1:OFF_W];
  assign acc_widx  = acc_idx[MEM_AW-1:0];
  assign acc_err   = (acc_addr[OFF_W-1:0] != '0) || !(32'(acc_idx) < DEPTH);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    enter_resp  = 1'b0;
    mem_we      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (wait_cnt != '0) begin
            state_d = StWait;
            cnt_d   = wait_cnt;
          end else begin
            enter_resp = 1'b1;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - WAIT_W'(1);
        if (cnt_q == WAIT_W'(1)) enter_resp = 1'b1;
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (enter_resp) begin
      state_d     = StResp;
      rsp_valid_d = 1'b1;
      rsp_err_d   = acc_err;
      rsp_rdata_d = (acc_err || acc_we) ? '0 : mem[acc_widx];
      mem_we      = acc_we && !acc_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Memory contents survive reset; only the write is gated by it.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (acc_be[b]) mem[acc_widx][b*8 +: 8] <= acc_wdata[b*8 +: 8];
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

`ifdef SBUS_RESP_STAT_EN
  logic [15:0] stat_rd_q, stat_rd_d;
  logic [15:0] stat_wr_q, stat_wr_d;
  logic [15:0] stat_err_q, stat_err_d;
  logic        rsp_hs;

  assign rsp_hs = rsp_valid_q && rsp_ready;

  // we_q always holds the in-flight request, including zero-wait ones.
  always_comb begin
    stat_rd_d  = stat_rd_q;
    stat_wr_d  = stat_wr_q;
    stat_err_d = stat_err_q;
    if (rsp_hs) begin
      if (rsp_err_q) begin
        if (stat_err_q != 16'hFFFF) stat_err_d = stat_err_q + 16'd1;
      end else if (we_q) begin
        if (stat_wr_q != 16'hFFFF) stat_wr_d = stat_wr_q + 16'd1;
      end else begin
        if (stat_rd_q != 16'hFFFF) stat_rd_d = stat_rd_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rd_q  <= '0;
      stat_wr_q  <= '0;
      stat_err_q <= '0;
    end else begin
      stat_rd_q  <= stat_rd_d;
      stat_wr_q  <= stat_wr_d;
      stat_err_q <= stat_err_d;
    end
  end

  assign stat_rd_cnt  = stat_rd_q;
  assign stat_wr_cnt  = stat_wr_q;
  assign stat_err_cnt = stat_err_q;
`endif

endmodule

// File: tb/tb_sbus_resp.sv
// Bench for sbus_resp: directed cases plus randomized traffic. The driver pushes the
// expected response (from a word-array model) into a queue at accept; a negedge monitor
// pops and compares on every response handshake and checks latency and stability.

module tb_sbus_resp;

  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int DEPTH = 256;
  localparam int WW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [WW-1:0] wait_cnt = '0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [3:0]    req_be = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
`ifdef SBUS_RESP_STAT_EN
  logic [15:0]   stat_rd, stat_wr, stat_err;
`endif

  sbus_resp #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_W(WW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wait_cnt  (wait_cnt),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
`ifdef SBUS_RESP_STAT_EN
    ,
    .stat_rd_cnt  (stat_rd),
    .stat_wr_cnt  (stat_wr),
    .stat_err_cnt (stat_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        we;
    int          rise_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_m [int];
  int          checks = 0;
  int          errors = 0;
  int          n_rd = 0, n_wr = 0, n_err = 0;
  bit          rdy_rand = 0;
  bit          rdy_hold = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response-side backpressure, changed just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rdy_hold)      rsp_ready = 1'b0;
    else if (rdy_rand) rsp_ready = ($urandom_range(0, 2) != 0);
    else               rsp_ready = 1'b1;
  end

  // Monitor
  logic        pv = 1'b0;
  logic        phs = 1'b0;
  logic [31:0] pdata;
  logic        perr;
  exp_t        me;

  always @(negedge clk) begin
    if (rst) begin
      pv  = 1'b0;
      phs = 1'b0;
    end else begin
      if (phs) begin
        check("post_hs_req_ready", 64'(req_ready), 64'd1);
        check("post_hs_rsp_valid", 64'(rsp_valid), 64'd0);
      end
      if (rsp_valid) begin
        check("busy_req_ready", 64'(req_ready), 64'd0);
        if (!pv) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got response expected none (cycle %0d)", cyc);
          end else begin
            check("latency", 64'(cyc), 64'(sb[0].rise_cyc));
          end
        end else begin
          check("stable_rdata", 64'(rsp_rdata), 64'(pdata));
          check("stable_err", 64'(rsp_err), 64'(perr));
        end
        if (rsp_ready && sb.size() > 0) begin
          me = sb.pop_front();
          check("rdata", 64'(rsp_rdata), 64'(me.rdata));
          check("err", 64'(rsp_err), 64'(me.err));
          if (me.err)     n_err++;
          else if (me.we) n_wr++;
          else            n_rd++;
        end
      end
      pv    = rsp_valid;
      pdata = rsp_rdata;
      perr  = rsp_err;
      phs   = rsp_valid && rsp_ready;
    end
  end

  // Drive one request, wait for accept, then update the model and scoreboard.
  task automatic issue(bit we, logic [15:0] addr, logic [31:0] wd, logic [3:0] be, int n,
                       bit commit = 1'b1);
    exp_t        e;
    int          guard = 0;
    int          idx;
    logic [31:0] w;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    wait_cnt  = WW'(n);
    while (!req_ready) begin
      guard++;
      if (guard > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got no accept expected accept within 200 cycles");
        req_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    if (commit) begin
      idx     = int'(addr) / 4;
      e.err   = (addr % 4 != 0) || (idx >= DEPTH);
      e.we    = we;
      e.rdata = 32'h0;
      if (!e.err && we) begin
        w = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
        for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
        mem_m[idx] = w;
      end else if (!e.err) begin
        e.rdata = mem_m[idx];
      end
      e.rise_cyc = cyc + n + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    // Scramble everything, including wait_cnt, once the request is in flight.
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = 16'($urandom);
    req_wdata = $urandom;
    req_be    = 4'($urandom);
    wait_cnt  = WW'($urandom);
  endtask

  task automatic drain();
    int g = 0;
    while ((sb.size() != 0 || rsp_valid) && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    check({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
`ifdef SBUS_RESP_STAT_EN
    check({tag, "_stat_rd"}, 64'(stat_rd), 64'd0);
    check({tag, "_stat_wr"}, 64'(stat_wr), 64'd0);
    check({tag, "_stat_err"}, 64'(stat_err), 64'd0);
`endif
  endtask

  initial begin
    logic [15:0] a;
    int          r;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(req_ready), 64'd1);

    // Write then read, zero wait.
    issue(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 0);
    issue(1'b0, 16'h0010, 32'h0, 4'h0, 0);
    // Byte lanes.
    issue(1'b1, 16'h0020, 32'h11223344, 4'hF, 0);
    issue(1'b1, 16'h0020, 32'hAABBCCDD, 4'b0101, 0);
    issue(1'b0, 16'h0020, 32'h0, 4'h0, 0);
    // Wait states (wait_cnt scrambled after accept).
    issue(1'b0, 16'h0010, 32'h0, 4'h0, 3);
    // Errors.
    issue(1'b1, 16'h0000, 32'hCAFE0000, 4'hF, 0);
    issue(1'b0, 16'h0002, 32'h0, 4'h0, 0);
    issue(1'b1, 16'h0400, 32'h55555555, 4'hF, 2);
    issue(1'b0, 16'h0000, 32'h0, 4'h0, 1);
    // All-zero byte enables.
    issue(1'b1, 16'h0010, 32'hFFFFFFFF, 4'h0, 1);
    issue(1'b0, 16'h0010, 32'h0, 4'h0, 2);
    drain();

    // Backpressure: hold rsp_ready low for several cycles.
    rdy_hold = 1'b1;
    issue(1'b0, 16'h0020, 32'h0, 4'h0, 0);
    repeat (5) @(negedge clk);
    rdy_hold = 1'b0;
    drain();

    // Reset while a write sits in WAIT.
    issue(1'b1, 16'h0030, 32'h0BADF00D, 4'hF, 0);
    drain();
    issue(1'b1, 16'h0030, 32'h12345678, 4'hF, 5, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midwait_reset");
    rst   = 1'b0;
    n_rd  = 0;
    n_wr  = 0;
    n_err = 0;
    issue(1'b0, 16'h0030, 32'h0, 4'h0, 0);
    drain();

    // Randomized traffic over a small initialised window plus error addresses.
    for (int i = 0; i < 16; i++) issue(1'b1, 16'(i * 4), $urandom, 4'hF, $urandom_range(0, 3));
    rdy_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       a = 16'($urandom_range(0, 15) * 4);
      else if (r == 8) a = 16'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
      else             a = 16'(16'h0400 + $urandom_range(0, 200) * 4);
      issue(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 4));
    end
    drain();
    rdy_rand = 1'b0;
    @(negedge clk);
`ifdef SBUS_RESP_STAT_EN
    check("stat_rd_cnt", 64'(stat_rd), 64'(n_rd));
    check("stat_wr_cnt", 64'(stat_wr), 64'(n_wr));
    check("stat_err_cnt", 64'(stat_err), 64'(n_err));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
